// File: rtl/axis_if.sv
// AXI4-Stream handshake bundle.
// master drives data/valid, slave drives ready.
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/axis_reg_fifo.sv
// AXI4-Stream elastic buffer: registered output word
// plus a small ring, registered in_ready.
module axis_reg_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_if.slave                in_s,
  axis_if.master               out_m,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 2);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-2];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic                  push, pop;
  logic                  arr_empty;
  logic                  we;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign push      = in_s.valid & ready_q;
  assign pop       = valid_q & out_m.ready;
  assign arr_empty = (cnt_q <= ONE);

  // Next state: bypass into the output word when
  // the ring is empty, otherwise go through the ring.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    we      = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + ONE;
        if (!valid_q) begin
          data_d  = in_s.data;
          valid_d = 1'b1;
        end else begin
          we   = 1'b1;
          wr_d = inc(wr_q);
        end
      end
      2'b01: begin
        cnt_d = cnt_q - ONE;
        if (arr_empty) begin
          valid_d = 1'b0;
        end else begin
          data_d = mem_q[rd_q];
          rd_d   = inc(rd_q);
        end
      end
      2'b11: begin
        if (arr_empty) begin
          data_d = in_s.data;
        end else begin
          data_d = mem_q[rd_q];
          rd_d   = inc(rd_q);
          we     = 1'b1;
          wr_d   = inc(wr_q);
        end
      end
      default: ;
    endcase
    ready_d = (cnt_d < FULL);
  end

  // Control and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Ring storage, written only on an accepted word.
  always_ff @(posedge aclk) begin
    if (aresetn && we) begin
      mem_q[wr_q] <= in_s.data;
    end
  end

  assign in_s.ready  = ready_q;
  assign out_m.data  = data_q;
  assign out_m.valid = valid_q;
  assign count       = cnt_q;
endmodule

// File: doc/axis_reg_fifo.md
# axis_reg_fifo

Parametrised AXI4-Stream elastic buffer that replaces the single-register output stage in our stream pipelines. It holds up to DEPTH words, drives out_data/out_valid straight from registers, and registers in_ready, so no combinational path runs from out_ready to in_ready. It sits between DSP/packer stages and DMA/DAC sinks, where backpressure has to be absorbed at full throughput without a long ready chain.

## Interface
- DATA_WIDTH, 32, width of in_data/out_data
- DEPTH, 4, total capacity in words, including the output register; power of two, ≥ 2
- CNT_WIDTH, $clog2(DEPTH)+1, width of count (derived, do not override)
- aclk  input  1  clock; all logic on rising edge
- aresetn  input  1  reset, synchronous, active-low
- in_data  input  DATA_WIDTH  upstream data
- in_valid  input  1  upstream valid
- in_ready  output  1  upstream ready, registered
- out_data  output  DATA_WIDTH  downstream data, registered
- out_valid  output  1  downstream valid, registered
- out_ready  input  1  downstream ready
- count  output  CNT_WIDTH  words held, registered, 0..DEPTH

## Operation
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Each is evaluated at the rising edge.
- Storage and ordering:
  - Output register plus a circular array of DEPTH-1 entries with read/write pointers.
  - Pointers wrap from DEPTH-2 to 0.
  - Strict FIFO order; no word is lost or duplicated.
- Next-state rules per edge, with n = count:
  - push only: n+1. If the output register is empty, or becomes empty on that edge, the word loads directly into it (bypass). Otherwise it is written to the array.
  - pop only: n-1. The output register reloads from the array head if the array is non-empty. Otherwise out_valid goes to 0.
  - push & pop: n unchanged. If n == 1, in_data goes straight to the output register. Otherwise the output register takes the array head and in_data is written to the array.
- Derived outputs:
  - out_valid = (count != 0), registered.
  - in_ready = (next count < DEPTH), registered from next-state logic.
- Full (count == DEPTH):
  - in_ready = 0, even when out_ready = 1; a pop in the same cycle does not enable a push.
  - in_ready returns to 1 on the edge that performs the pop.
- Empty (count == 0):
  - out_valid = 0.
  - out_ready is ignored; no pop and no underflow.
- out_data is stable while out_valid & ~out_ready (AXI-Stream hold rule).
- Writes to the array and data path are gated by push only; in_data is never sampled when in_valid = 0.

## Timing
- Reset (aresetn = 0 at an edge), output values:
  - out_valid = 0
  - count = 0
  - in_ready = 0
  - out_data = 0
  - pointers = 0
- Reset overrides any simultaneous push or pop.
- After reset:
  - in_ready rises to 1 at the first edge with aresetn = 1.
  - in_valid during that first cycle is not accepted (in_ready is still 0).
- Reset mid-operation discards all stored words. out_valid is 0 in the following cycle.
- Latency, empty buffer: a word pushed at edge k has out_valid = 1 and out_data = word from edge k onward, so it is visible in cycle k+1.
- Throughput: 1 word/cycle sustained with in_valid = out_ready = 1 at any fill level ≥ 1, including full.
- Ready rule: in_ready depends only on registered state. out_ready reaches only out_valid/out_data/count next-state logic.
- count updates on the same edge as the handshake it reflects.

## Test plan
- Reset: hold aresetn = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, count = 0, in_ready = 0 throughout. in_ready = 1 one edge after release, with no word accepted before that.
- Fill/drain, DEPTH = 4, out_ready = 0:
  - Push 0x11, 0x22, 0x33, 0x44 -> count goes 1, 2, 3, 4; in_ready = 0 after the 4th push; 0x55 is held off.
  - Then out_ready = 1 -> outputs 0x11, 0x22, 0x33, 0x44, 0x55 in order.
- Full with simultaneous ready: at count = 4, in_valid = out_ready = 1 for one cycle -> one pop, no push, count = 3, in_ready = 1 next cycle.
- Streaming: 1000 words, incrementing from 0, with in_valid = out_ready = 1 constant -> one word out per cycle, first word in the cycle after its push, count stays 1.
- Random backpressure: in_valid and out_ready each random at 50%, 10000 words, DEPTH = 2 and 16 -> output sequence equals input sequence. Per cycle:
  - out_data is held while stalled;
  - count is never above DEPTH;
  - no pop occurs when count = 0.
- Mid-run reset: assert aresetn = 0 for one edge at count = 3 -> count = 0 and out_valid = 0 next cycle; no pre-reset word appears afterwards.
